// File: rtl/i2s_tx.sv
// I2S transmitter: 16-bit stereo, Philips format, BCLK = clk/32, LRCLK = clk/1024.
// One frame is 1024 master clocks (32 slots of 32 clocks). A single-entry holding
// register decouples the upstream handshake from the frame timing. The holding
// register is copied into the shifter once per frame, at the start of slot 1.
module i2s_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_data,
    output logic        underrun
);

    logic [9:0]  r_cnt;
    logic [31:0] r_shreg;
    logic        r_holdFull;
    logic [31:0] r_holdData;
    logic        r_bclk;
    logic        r_lrclk;
    logic        r_underrun;

    logic        w_clear;
    logic [9:0]  w_cntNext;
    logic        w_load;
    logic        w_shift;
    logic        w_accept;

    // An unlocked clock generator is treated exactly like reset.
    assign w_clear   = rst | ~pll_locked;
    assign w_cntNext = r_cnt + 10'd1;
    // The shifter is reloaded on the edge that starts slot 1. The one-slot offset
    // from the LRCLK transition is the standard I2S one-BCLK data delay.
    assign w_load    = (w_cntNext == 10'd32);
    // Every other slot boundary advances the shifter by one bit.
    assign w_shift   = (w_cntNext[4:0] == 5'd0) && !w_load;
    assign w_accept  = sample_valid & sample_ready;

    assign sample_ready = ~r_holdFull & pll_locked & ~rst;
    assign i2s_bclk     = r_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_data     = r_shreg[31];
    assign underrun     = r_underrun;

    // Free-running frame position counter, wraps 1023 -> 0.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cnt <= 10'd0;
        end else begin
            r_cnt <= w_cntNext;
        end
    end

    // BCLK and LRCLK are registered copies of the counter bits so they always equal cnt[4] and cnt[9].
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
        end else begin
            r_bclk  <= w_cntNext[4];
            r_lrclk <= w_cntNext[9];
        end
    end

    // Output shifter: load at slot 1 with the held sample (or silence), then shift MSB first.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_shreg <= 32'h0;
        end else if (w_load) begin
            r_shreg <= r_holdFull ? r_holdData : 32'h0;
        end else if (w_shift) begin
            r_shreg <= {r_shreg[30:0], 1'b0};
        end
    end

    // Holding register. A sample accepted on the load edge itself goes into the holding register rather than the shifter.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_holdFull <= 1'b0;
            r_holdData <= 32'h0;
        end else if (w_accept) begin
            r_holdFull <= 1'b1;
            r_holdData <= {sample_left, sample_right};
        end else if (w_load) begin
            r_holdFull <= 1'b0;
        end
    end

    // Underrun flag is high only in the cnt==32 cycle that follows a silent load.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load & ~r_holdFull;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-level reference model predicts every
// output in every cycle, and a slot-midpoint receiver reassembles the words on
// the wire so that they can be compared with known samples.
module tb_i2s_tx;

    logic        clk;
    logic        rst;
    logic        pllLocked;
    logic        sampleValid;
    logic        sampleReady;
    logic [15:0] sampleLeft;
    logic [15:0] sampleRight;
    logic        i2sBclk;
    logic        i2sLrclk;
    logic        i2sData;
    logic        underrun;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: position in the frame, holding register, and the word currently on the wire.
    int          mCnt   = 0;
    bit          mFull  = 0;
    logic [31:0] mHold  = 32'h0;
    logic [31:0] mWord  = 32'h0;
    bit          mUnder = 0;
    bit          lastAccept = 0;

    // Receiver state.
    logic [31:0] rxWord = 32'h0;
    logic [31:0] lastRx = 32'h0;

    logic [15:0] sL [0:6];
    logic [15:0] sR [0:6];

    i2s_tx dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pllLocked),
        .sample_valid (sampleValid),
        .sample_ready (sampleReady),
        .sample_left  (sampleLeft),
        .sample_right (sampleRight),
        .i2s_bclk     (i2sBclk),
        .i2s_lrclk    (i2sLrclk),
        .i2s_data     (i2sData),
        .underrun     (underrun)
    );

    // Master clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (model cnt %0d, t=%0t)", tag, obs, exp, mCnt, $time);
        end
    endtask

    // Drive one cycle of inputs, check every output against the model, then advance the model.
    task automatic applyStimulus(input bit r, input bit lk, input bit v,
                                 input logic [15:0] l, input logic [15:0] rr);
        int   c;
        int   s;
        int   nxt;
        bit   acc;
        logic expData;
        @(negedge clk);
        rst = r;
        pllLocked = lk;
        sampleValid = v;
        sampleLeft = l;
        sampleRight = rr;
        #1;
        c = mCnt;
        s = c / 32;
        expData = (s == 0) ? mWord[0] : mWord[32 - s];
        checkOutput("bclk", i2sBclk, ((c / 16) % 2));
        checkOutput("lrclk", i2sLrclk, (c >= 512) ? 1 : 0);
        checkOutput("data", i2sData, expData);
        checkOutput("underrun", underrun, mUnder);
        checkOutput("ready", sampleReady, (!mFull && lk && !r) ? 1 : 0);
        if (c % 32 == 16) begin
            if (s == 0) begin
                rxWord[0] = i2sData;
                lastRx = rxWord;
            end else begin
                rxWord[32 - s] = i2sData;
            end
        end
        acc = v && !mFull && lk && !r;
        lastAccept = acc;
        if (r || !lk) begin
            mCnt = 0;
            mFull = 0;
            mHold = 32'h0;
            mWord = 32'h0;
            mUnder = 0;
        end else begin
            nxt = (mCnt + 1) % 1024;
            if (nxt == 32) begin
                mWord = mFull ? mHold : 32'h0;
                mUnder = !mFull;
                mFull = 0;
            end else begin
                mUnder = 0;
            end
            if (acc) begin
                mHold = {l, rr};
                mFull = 1;
            end
            mCnt = nxt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 16'($urandom), 16'($urandom));
    endtask

    task automatic waitCnt(input int c);
        int guard = 0;
        while (mCnt != c && guard < 2048) begin
            idle(1);
            guard++;
        end
        if (mCnt != c) checkOutput("waitCnt_timeout", mCnt, c);
    endtask

    // Advance to cnt 17 of the next frame, by which time lastRx holds the word that just finished.
    task automatic nextFrameRx();
        waitCnt(0);
        waitCnt(17);
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] rr);
        int guard = 0;
        lastAccept = 0;
        while (!lastAccept && guard < 3000) begin
            applyStimulus(0, 1, 1, l, rr);
            guard++;
        end
        if (!lastAccept) checkOutput("offer_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        pllLocked = 1'b1;
        sampleValid = 1'b0;
        sampleLeft = 16'h0;
        sampleRight = 16'h0;
        for (int i = 1; i < 7; i++) begin
            sL[i] = 16'($urandom) | 16'h8001;
            sR[i] = 16'($urandom) | 16'h0001;
        end
        repeat (3) @(negedge clk);

        // Reset state, then two silent frames.
        applyStimulus(1, 1, 0, 16'h0, 16'h0);
        applyStimulus(1, 1, 1, 16'h1234, 16'h5678);
        applyStimulus(0, 1, 0, 16'h0, 16'h0);
        checkOutput("release_ready", sampleReady, 1);
        idle(2047);

        // Known sample offered at cnt 5.
        waitCnt(5);
        applyStimulus(0, 1, 1, 16'hA5C3, 16'h5A3C);
        checkOutput("known_accept", lastAccept, 1);
        nextFrameRx();
        checkOutput("known_word", lastRx, 32'hA5C35A3C);

        // Two samples back to back with valid held high.
        waitCnt(100);
        offer(sL[1], sR[1]);
        offer(sL[2], sR[2]);
        nextFrameRx();
        checkOutput("b2b_first", lastRx, {sL[1], sR[1]});
        nextFrameRx();
        checkOutput("b2b_second", lastRx, {sL[2], sR[2]});

        // Sample arriving in the cnt==31 cycle misses this frame.
        waitCnt(31);
        applyStimulus(0, 1, 1, sL[3], sR[3]);
        idle(1);
        checkOutput("late_underrun", underrun, 1);
        nextFrameRx();
        checkOutput("late_zero_frame", lastRx, 32'h0);
        nextFrameRx();
        checkOutput("late_word", lastRx, {sL[3], sR[3]});

        // Clock-generator loss at slot 20 with a sample held.
        waitCnt(40);
        offer(sL[4], sR[4]);
        waitCnt(640);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, i[0], sL[5], sR[5]);
        checkOutput("pll_cnt_restart", mCnt, 0);
        waitCnt(32);
        idle(1);
        checkOutput("pll_underrun", underrun, 1);
        nextFrameRx();
        checkOutput("pll_sample_lost", lastRx, 32'h0);

        // Reset during slot 8 of a loaded frame, with a second sample held.
        waitCnt(40);
        offer(sL[5], sR[5]);
        offer(sL[6], sR[6]);
        waitCnt(260);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, sL[1], sR[1]);
        applyStimulus(0, 1, 0, 16'h0, 16'h0);
        checkOutput("rst_release_ready", sampleReady, 1);
        waitCnt(32);
        idle(1);
        checkOutput("rst_underrun", underrun, 1);
        nextFrameRx();
        checkOutput("rst_sample_lost", lastRx, 32'h0);

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            applyStimulus(0, 1, ($urandom % 16) == 0, 16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 clk  in  1  audio master clock, 49.152 MHz (1024 x 48 kHz); all logic on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 pll_locked  in  1  clock-generator lock status, synchronous to clk; low = clock not valid.
REQ-004 sample_valid  in  1  upstream stereo sample present.
REQ-005 sample_ready  out  1  block accepts a sample this cycle.
REQ-006 sample_left  in  16  left sample, two's complement, MSB first on the wire.
REQ-007 sample_right  in  16  right sample, two's complement.
REQ-008 i2s_bclk  out  1  bit clock, clk/32 = 1.536 MHz.
REQ-009 i2s_lrclk  out  1  word select, 48 kHz; 0 = left, 1 = right.
REQ-010 i2s_data  out  1  serial data, Philips I2S format.
REQ-011 underrun  out  1  one-cycle pulse: frame sent with no sample available.

Function
REQ-012 The block SHALL keep a 10-bit free-running counter cnt, 0..1023, wrapping 1023->0; slot = cnt[9:5] (0..31).
REQ-013 i2s_bclk SHALL equal cnt[4]: low for cnt[4:0] 0..15, high for 16..31; falling edge on the clock edge at which cnt[4:0] becomes 0.
REQ-014 i2s_lrclk SHALL equal cnt[9]: 0 for slots 0..15, 1 for slots 16..31.
REQ-015 i2s_data SHALL equal bit 31 of a 32-bit shift register shreg; all outputs driven directly from flops, no combinational decode.
REQ-016 On the edge at which cnt becomes 32 (slot 1 start), shreg SHALL load {left,right} from the holding register if full, else 32'h0.
REQ-017 On every other edge at which cnt[4:0] becomes 0, shreg SHALL shift left by one, filling with 0.
REQ-018 Result: slot 1 carries left[15], slot 16 left[0], slot 17 right[15], slot 31 right[1], next frame's slot 0 right[0] (one-BCLK I2S delay).
REQ-019 Holding register: one entry {left,right} plus flag hold_full; sample_ready = ~hold_full & pll_locked & ~rst.
REQ-020 Transfer occurs when sample_valid & sample_ready; hold_full sets on the next edge.
REQ-021 The load edge in REQ-016 SHALL clear hold_full; a sample offered in that same cycle while the register is empty SHALL be accepted into the holding register, not bypassed to shreg, and the zero frame still counts as underrun.
REQ-022 underrun SHALL be high exactly during the cycle cnt==32 when the load was a zero load.
REQ-023 While pll_locked is low, the block SHALL behave as in reset (REQ-024) every cycle; on return high, cnt restarts at 0 and the first frame is an underrun unless a sample is accepted before cnt reaches 32.

Reset
REQ-024 While rst is high: cnt=0, shreg=0, hold_full=0, holding data=0, i2s_bclk=0, i2s_lrclk=0, i2s_data=0, underrun=0, sample_ready=0.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no partial-word resumption; any held sample is discarded.
REQ-026 First cycle after rst falls with pll_locked high: cnt=0, sample_ready=1.

Verification
REQ-027 Reset then idle 2 frames, no samples -> i2s_bclk period 32 clk, i2s_lrclk period 1024 clk, i2s_data constant 0, underrun pulses at cnt==32 in each frame.
REQ-028 Offer L=16'hA5C3, R=16'h5A3C at cnt=5 -> accepted same cycle; slots 1..16 = A5C3 MSB first, slots 17..31 = 5A3C[15:1], next slot 0 = 0; no underrun that frame.
REQ-029 Hold sample_valid high with two different samples back-to-back -> first accepted, sample_ready low until the cnt==32 edge, second accepted on the next cycle and transmitted in the following frame.
REQ-030 Sample offered exactly in cycle cnt==31 with register empty -> accepted, frame is a zero frame with underrun=1 at cnt==32, sample sent next frame.
REQ-031 Drop pll_locked for 10 cycles mid-frame (slot 20) -> all outputs 0 and sample_ready 0 while low; cnt=0 after recovery; held sample lost.
REQ-032 Assert rst during slot 8 of a loaded frame -> outputs 0 next cycle, hold_full=0; after release, timing restarts from cnt=0.
